uart_cmd_ctrl: RTL

//  Command sequencer behind the UART receiver: consumes its byte/valid stream, parses framed

---
 rtl/uart_cmd_ctrl_if.sv | 37 +++
 rtl/uart_cmd_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl_if.sv
// Bus between the UART receiver, the command sequencer and the DSP config register file.
// The receive side (byte/valid) flows into the sequencer. The write side (strobe/addr/data)
// plus the status outputs flow out of it.
interface uart_cmd_ctrl_if;
    logic        i_Rx_DV;
    logic [7:0]  i_Rx_Byte;
    logic        o_Reg_WE;
    logic [2:0]  o_Reg_Addr;
    logic [31:0] o_Reg_Data;
    logic [31:0] o_Freq_Word;
    logic        o_Err;
    logic        o_Busy;

    // Byte source side (uart_rx or a bench driver)
    modport master (
        output i_Rx_DV,
        output i_Rx_Byte,
        input  o_Reg_WE,
        input  o_Reg_Addr,
        input  o_Reg_Data,
        input  o_Freq_Word,
        input  o_Err,
        input  o_Busy
    );

    // Command sequencer side
    modport slave (
        input  i_Rx_DV,
        input  i_Rx_Byte,
        output o_Reg_WE,
        output o_Reg_Addr,
        output o_Reg_Data,
        output o_Freq_Word,
        output o_Err,
        output o_Busy
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: parses SYNC, ADDR, D0..D3 (LSB first) [, CSUM] frames from the
// uart_rx byte stream and issues one register-file write per good frame. Register 0 is also
// shadowed on o_Freq_Word for the NCO. A stalled frame is aborted by an inter-byte timeout.
// Build option: define UART_CMD_CHECKSUM_EN to append and verify an XOR checksum byte
// (7-byte frame). Without it the frame is 6 bytes and commits straight after D3.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | hunting for SYNC_BYTE, other bytes silently dropped
// S_ADDR   | expecting the register address byte
// S_DATA   | collecting D0..D3 into the 32-bit word, LSB first
// S_CSUM   | expecting XOR of ADDR and D0..D3 (checksum build only)
// S_COMMIT | single cycle: write strobe out, then back to S_IDLE
module uart_cmd_ctrl #(
    parameter int          CLKS_PER_BIT = 1155,
    parameter int          TIMEOUT_BITS = 40,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          NUM_REGS     = 8,
    parameter logic [31:0] FREQ_RESET   = 32'd0
) (
    input  logic            osc_clk,
    input  logic            i_Reset,
    uart_cmd_ctrl_if.slave  bus
);

    // The abort fires on the cycle the counter has reached the limit minus one,
    // so a full CLKS_PER_BIT*TIMEOUT_BITS cycles of silence ends the frame.
    localparam logic [23:0] TMO_LAST   = 24'(CLKS_PER_BIT * TIMEOUT_BITS - 1);
    localparam logic [3:0]  NUM_REGS_W = 4'(NUM_REGS);

`ifdef UART_CMD_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_COMMIT = 3'd4
    } t_state;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_DATA   = 3'd2,
        S_COMMIT = 3'd4
    } t_state;
`endif

    t_state      r_state;
    t_state      w_state_next;

    logic [23:0] r_tmo_cnt;
    logic [2:0]  r_addr;
    logic [2:0]  w_addr_next;
    logic [31:0] r_data;
    logic [31:0] w_data_next;
    logic [1:0]  r_idx;
    logic [1:0]  w_idx_next;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]  r_acc;
    logic [7:0]  w_acc_next;
`endif

    logic        r_we;
    logic [2:0]  r_reg_addr;
    logic [31:0] r_reg_data;
    logic [31:0] r_freq;
    logic        r_err;

    logic        w_timeout;
    logic        w_addr_bad;
    logic        w_err;

    assign w_addr_bad = (bus.i_Rx_Byte[7:3] != 5'd0) ||
                        ({1'b0, bus.i_Rx_Byte[2:0]} >= NUM_REGS_W);

    // A byte arriving on the limit cycle takes priority over the abort.
    assign w_timeout  = (r_state != S_IDLE) && !bus.i_Rx_DV && (r_tmo_cnt >= TMO_LAST);

    // State register
    always_ff @(posedge osc_clk) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and frame field assembly
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_data_next  = r_data;
        w_idx_next   = r_idx;
        w_err        = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
        w_acc_next   = r_acc;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.i_Rx_DV && (bus.i_Rx_Byte == SYNC_BYTE)) begin
                    w_state_next = S_ADDR;
`ifdef UART_CMD_CHECKSUM_EN
                    w_acc_next   = 8'd0;
`endif
                end
            end
            S_ADDR: begin
                if (bus.i_Rx_DV) begin
                    if (w_addr_bad) begin
                        w_err        = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_addr_next  = bus.i_Rx_Byte[2:0];
                        w_idx_next   = 2'd0;
                        w_state_next = S_DATA;
`ifdef UART_CMD_CHECKSUM_EN
                        w_acc_next   = bus.i_Rx_Byte;
`endif
                    end
                end
            end
            S_DATA: begin
                if (bus.i_Rx_DV) begin
                    w_data_next[{r_idx, 3'b000} +: 8] = bus.i_Rx_Byte;
                    w_idx_next = r_idx + 2'd1;
`ifdef UART_CMD_CHECKSUM_EN
                    w_acc_next = r_acc ^ bus.i_Rx_Byte;
                    if (r_idx == 2'd3) begin
                        w_state_next = S_CSUM;
                    end
`else
                    if (r_idx == 2'd3) begin
                        w_state_next = S_COMMIT;
                    end
`endif
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            S_CSUM: begin
                if (bus.i_Rx_DV) begin
                    if (bus.i_Rx_Byte == r_acc) begin
                        w_state_next = S_COMMIT;
                    end else begin
                        w_err        = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
`endif
            S_COMMIT: begin
                // A byte here cannot arrive at a legal baud rate; it is dropped.
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_timeout) begin
            w_err        = 1'b1;
            w_state_next = S_IDLE;
        end
    end

    // Inter-byte timeout down the frame: cleared by every byte and while idle, saturating
    always_ff @(posedge osc_clk) begin
        if (i_Reset) begin
            r_tmo_cnt <= 24'd0;
        end else if (bus.i_Rx_DV || (r_state == S_IDLE) || w_timeout) begin
            r_tmo_cnt <= 24'd0;
        end else if (r_tmo_cnt != 24'hFF_FFFF) begin
            r_tmo_cnt <= r_tmo_cnt + 24'd1;
        end
    end

    // Frame field registers
    always_ff @(posedge osc_clk) begin
        if (i_Reset) begin
            r_addr <= 3'd0;
            r_data <= 32'd0;
            r_idx  <= 2'd0;
        end else begin
            r_addr <= w_addr_next;
            r_data <= w_data_next;
            r_idx  <= w_idx_next;
        end
    end

`ifdef UART_CMD_CHECKSUM_EN
    // Running XOR of ADDR and data bytes
    always_ff @(posedge osc_clk) begin
        if (i_Reset) begin
            r_acc <= 8'd0;
        end else begin
            r_acc <= w_acc_next;
        end
    end
`endif

    // Write port: loaded on entry to S_COMMIT so addr/data are valid with the strobe
    // and hold afterwards; the frequency shadow follows on the commit edge
    always_ff @(posedge osc_clk) begin
        if (i_Reset) begin
            r_we       <= 1'b0;
            r_reg_addr <= 3'd0;
            r_reg_data <= 32'd0;
            r_freq     <= FREQ_RESET;
            r_err      <= 1'b0;
        end else begin
            r_we  <= (w_state_next == S_COMMIT);
            r_err <= w_err;
            if (w_state_next == S_COMMIT) begin
                r_reg_addr <= r_addr;
                r_reg_data <= w_data_next;
            end
            if ((r_state == S_COMMIT) && (r_reg_addr == 3'd0)) begin
                r_freq <= r_reg_data;
            end
        end
    end

    assign bus.o_Reg_WE    = r_we;
    assign bus.o_Reg_Addr  = r_reg_addr;
    assign bus.o_Reg_Data  = r_reg_data;
    assign bus.o_Freq_Word = r_freq;
    assign bus.o_Err       = r_err;
    assign bus.o_Busy      = (r_state != S_IDLE);

endmodule
